mult_sequencer: RTL and testbench
=================================

// Module: mult_sequencer
// PURPOSE
//  Multi-cycle controller for the signed MULT operation (ALU control code 6) in the EX stage.
//  Detects a MULT issued to the ALU and runs an iterative radix-2 shift-add multiply.
//  Stalls the pipeline while the multiply is in progress.
//  Writes the 2*DATA_W product into the HI/LO registers; the MFHI/MFLO path reads them.
// PARAMETERS
//  DATA_W   32    operand width; HI and LO are each DATA_W bits
//  MULT_OP  4'd6  alu_control code that starts a multiply
//  CNT_W    6     iteration counter width; must satisfy 2^CNT_W > DATA_W
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       synchronous, active-low reset
//  alu_valid    in   1       a valid instruction occupies EX this cycle
//  alu_control  in   4       ALU control code for the instruction in EX
//  operand_a    in   DATA_W  rs value, two's complement
//  operand_b    in   DATA_W  rt value, two's complement
//  flush        in   1       EX squash (branch/exception); aborts the multiply
//  stall        out  1       hold IF/ID/EX; combinational
//  busy         out  1       state != IDLE; registered
//  done         out  1       one-cycle pulse: HI/LO hold the new product
//  hi           out  DATA_W  upper half of the last completed product
//  lo           out  DATA_W  lower half of the last completed product
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, count=0, hi=0, lo=0, done=0, busy=0.
//   The reset overrides every other input. A reset mid-RUN discards the operation.
//  start = alu_valid & (alu_control==MULT_OP) & ~flush & (state==IDLE).
//  State IDLE:
//   - On start: latch mag_a=|operand_a|, mag_b=|operand_b|, neg=a[MSB]^b[MSB]; acc=0; count=0; go to RUN.
//   - Otherwise stay in IDLE.
//  State RUN: one iteration per cycle.
//   - If mag_b[0]: acc += mag_a << count.
//   - Then mag_b >>= 1 and count++.
//   - On the iteration where count==DATA_W-1: {hi,lo} <= neg ? -acc_next : acc_next; go to DONE.
//  State DONE:
//   - done=1 for exactly one cycle, then go to IDLE unconditionally.
//   - The MULT is still in EX during this cycle. Any start condition in DONE is ignored.
//  stall = (state==IDLE & start) | (state==RUN).
//   - stall is 0 in DONE, so the MULT leaves EX at the end of the DONE cycle.
//  Latency:
//   - Start cycle T0, RUN for T1..T(DATA_W), DONE at T(DATA_W+1).
//   - stall is high for DATA_W+1 consecutive cycles.
//  Arithmetic:
//   - Magnitudes are unsigned DATA_W bits, so |-2^(DATA_W-1)| is representable. acc is 2*DATA_W bits.
//   - The final negate is 2*DATA_W two's complement, so the result is exact with no overflow.
//  Operands are sampled only at T0. Later changes on operand_a/b have no effect.
//  flush:
//   - In RUN or DONE: go to IDLE next cycle; hi/lo keep their old values; done stays 0.
//   - In the same cycle as a potential start: no start.
//  hi/lo change only on the completing RUN edge or on reset.
// TESTING
//  1. 3 * -5: stall high 33 cycles, done at T33, hi=32'hFFFFFFFF, lo=32'hFFFFFFF1.
//  2. 32'h80000000 * 32'h80000000 -> hi=32'h40000000, lo=0.
//     32'h7FFFFFFF * 32'h80000000 -> hi=32'hC0000000, lo=32'h80000000.
//  3. 0 * -1 -> hi=0, lo=0 (no negative zero); done pulses exactly once.
//  4. flush at T10 -> IDLE at T11, busy=0, done never pulses, hi/lo unchanged.
//     A new MULT 7*6 then yields lo=42.
//  5. rst_n low at T5 of a run -> next cycle all outputs 0, state IDLE.
//     A MULT held valid through DONE does not restart.
//  6. Random 1000-pair signed sweep vs $signed reference product.
//     Back-to-back MULTs: second starts at the first IDLE after DONE.

Source files
------------

// File: rtl/mult_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mult_sequencer                                               |
// | Description : EX-stage controller for signed MULT. Runs a radix-2          |
// |               shift-add multiply over DATA_W cycles, stalls the pipeline   |
// |               while it runs and writes the 2*DATA_W product into HI/LO.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mult_sequencer #(
  parameter int         DATA_W  = 32,
  parameter logic [3:0] MULT_OP = 4'd6,
  parameter int         CNT_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid_i,
  input  logic [3:0]        alu_control_i,
  input  logic [DATA_W-1:0] operand_a_i,
  input  logic [DATA_W-1:0] operand_b_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int               c_PROD_W   = 2 * DATA_W;
  localparam logic [1:0]       c_IDLE     = 2'd0;
  localparam logic [1:0]       c_RUN      = 2'd1;
  localparam logic [1:0]       c_DONE     = 2'd2;
  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(DATA_W - 1);

  logic [1:0]          state_q, state_d;
  logic                busy_q;
  logic [DATA_W-1:0]   mag_a_q, mag_a_d;
  logic [DATA_W-1:0]   mag_b_q, mag_b_d;
  logic                neg_q, neg_d;
  logic [c_PROD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  logic                w_start;
  logic                w_last;
  logic [c_PROD_W-1:0] w_addend;
  logic [c_PROD_W-1:0] w_acc_next;
  logic [c_PROD_W-1:0] w_product;

  // A squashed instruction never starts a multiply; DONE/RUN ignore new MULTs.
  assign w_start = alu_valid_i && (alu_control_i == MULT_OP) && !flush_i &&
                   (state_q == c_IDLE);
  assign w_last  = (count_q == c_LAST_CNT);

  // Partial product for this iteration; magnitudes are unsigned so the
  // most negative operand still has a representable magnitude.
  assign w_addend   = mag_b_q[0] ? ({{DATA_W{1'b0}}, mag_a_q} << count_q) : '0;
  assign w_acc_next = acc_q + w_addend;
  // Sign is applied once at the end over the full product width, so it is exact.
  assign w_product  = neg_q ? -w_acc_next : w_acc_next;

  // State register; busy is registered from the next state so it is glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != c_IDLE);
    end
  end

  // Next-state logic; flush abandons the multiply, DONE always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (w_start) state_d = c_RUN;
      c_RUN: begin
        if (flush_i)     state_d = c_IDLE;
        else if (w_last) state_d = c_DONE;
      end
      c_DONE:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // Outputs: the start cycle already stalls; DONE releases the MULT from EX.
  always_comb begin
    stall_o = ((state_q == c_IDLE) && w_start) || (state_q == c_RUN);
    done_o  = (state_q == c_DONE) && !flush_i;
    busy_o  = busy_q;
    hi_o    = hi_q;
    lo_o    = lo_q;
  end

  // Datapath next values: latch operands at start, iterate in RUN, commit on last.
  always_comb begin
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == c_IDLE) begin
      if (w_start) begin
        mag_a_d = operand_a_i[DATA_W-1] ? -operand_a_i : operand_a_i;
        mag_b_d = operand_b_i[DATA_W-1] ? -operand_b_i : operand_b_i;
        neg_d   = operand_a_i[DATA_W-1] ^ operand_b_i[DATA_W-1];
        acc_d   = '0;
        count_d = '0;
      end
    end else if ((state_q == c_RUN) && !flush_i) begin
      acc_d   = w_acc_next;
      mag_b_d = mag_b_q >> 1;
      count_d = count_q + CNT_W'(1);
      if (w_last) begin
        hi_d = w_product[c_PROD_W-1:DATA_W];
        lo_d = w_product[DATA_W-1:0];
      end
    end
  end

  // Datapath registers; reset discards any operation in flight and clears HI/LO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mult_sequencer                                            |
// | Description : Self-checking bench for mult_sequencer: directed corner      |
// |               cases, flush, reset abort and a random signed sweep.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mult_sequencer;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [3:0]  alu_control;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  mult_sequencer #(.DATA_W(32), .MULT_OP(4'd6), .CNT_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid_i  (alu_valid),
    .alu_control_i(alu_control),
    .operand_a_i  (operand_a),
    .operand_b_i  (operand_b),
    .flush_i      (flush),
    .stall_o      (stall),
    .busy_o       (busy),
    .done_o       (done),
    .hi_o         (hi),
    .lo_o         (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the exact signed product, straight from integer arithmetic.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    int     sa;
    int     sb;
    longint p;
    sa = a;
    sb = b;
    p  = longint'(sa) * longint'(sb);
    return p;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue a MULT in the current cycle (T0) and follow it to its DONE cycle.
  // Leaves the bench in the DONE cycle with the MULT still valid in EX.
  task automatic mult_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int          cyc;
    int          n_stall;
    logic        got_done;
    logic        stall_at_done;
    logic        busy_at_done;
    exp         = ref_prod(a, b);
    alu_valid   = 1'b1;
    alu_control = 4'd6;
    operand_a   = a;
    operand_b   = b;
    flush       = 1'b0;
    #1;
    chk({tag, "_t0_stall"}, 64'(stall), 64'(1));
    chk({tag, "_t0_busy"}, 64'(busy), 64'(0));
    n_stall       = 1;
    cyc           = 0;
    got_done      = 1'b0;
    stall_at_done = 1'b0;
    busy_at_done  = 1'b0;
    while (!got_done && cyc < 60) begin
      step();
      cyc++;
      operand_a = $urandom;
      operand_b = $urandom;
      #1;
      if (cyc == 1) begin
        chk({tag, "_t1_hi_hold"}, 64'(hi), 64'(last_hi));
        chk({tag, "_t1_lo_hold"}, 64'(lo), 64'(last_lo));
      end
      if (done) begin
        got_done      = 1'b1;
        stall_at_done = stall;
        busy_at_done  = busy;
      end else if (stall) begin
        n_stall++;
      end
    end
    chk({tag, "_done_seen"}, 64'(got_done), 64'(1));
    chk({tag, "_done_cycle"}, 64'(cyc), 64'(33));
    chk({tag, "_stall_cycles"}, 64'(n_stall), 64'(33));
    chk({tag, "_stall_in_done"}, 64'(stall_at_done), 64'(0));
    chk({tag, "_busy_in_done"}, 64'(busy_at_done), 64'(1));
    chk({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
    chk({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
    last_hi = exp[63:32];
    last_lo = exp[31:0];
  endtask

  // After DONE, retire the MULT and confirm the pulse lasted one cycle.
  task automatic retire(input string tag);
    step();
    alu_valid = 1'b0;
    #1;
    chk({tag, "_done_once"}, 64'(done), 64'(0));
    chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
    chk({tag, "_idle_stall"}, 64'(stall), 64'(0));
  endtask

  initial begin
    int n_done;
    rst_n       = 1'b0;
    alu_valid   = 1'b0;
    alu_control = 4'd0;
    operand_a   = '0;
    operand_b   = '0;
    flush       = 1'b0;
    repeat (3) step();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    rst_n = 1'b1;
    step();

    // A non-MULT code and a flushed MULT must not start anything.
    alu_valid   = 1'b1;
    alu_control = 4'd5;
    operand_a   = 32'd3;
    operand_b   = 32'd4;
    #1;
    chk("other_op_stall", 64'(stall), 64'(0));
    step();
    chk("other_op_busy", 64'(busy), 64'(0));
    alu_control = 4'd6;
    flush       = 1'b1;
    #1;
    chk("flush_start_stall", 64'(stall), 64'(0));
    step();
    chk("flush_start_busy", 64'(busy), 64'(0));
    flush     = 1'b0;
    alu_valid = 1'b0;
    step();

    // Directed corner products, with fixed expected halves as well.
    mult_op("m3xm5", 32'd3, 32'hFFFF_FFFB);
    chk("m3xm5_hi_const", 64'(hi), 64'(32'hFFFF_FFFF));
    chk("m3xm5_lo_const", 64'(lo), 64'(32'hFFFF_FFF1));
    retire("m3xm5");
    step();
    mult_op("minxmin", 32'h8000_0000, 32'h8000_0000);
    chk("minxmin_hi_const", 64'(hi), 64'(32'h4000_0000));
    chk("minxmin_lo_const", 64'(lo), 64'(32'h0000_0000));
    retire("minxmin");
    step();
    mult_op("maxxmin", 32'h7FFF_FFFF, 32'h8000_0000);
    chk("maxxmin_hi_const", 64'(hi), 64'(32'hC000_0000));
    chk("maxxmin_lo_const", 64'(lo), 64'(32'h8000_0000));
    retire("maxxmin");
    step();
    mult_op("zxm1", 32'd0, 32'hFFFF_FFFF);
    chk("zxm1_hi_const", 64'(hi), 64'(0));
    chk("zxm1_lo_const", 64'(lo), 64'(0));
    retire("zxm1");
    step();

    // Flush at T10 of a run: back to IDLE, no done, HI/LO untouched.
    alu_valid   = 1'b1;
    alu_control = 4'd6;
    operand_a   = 32'd5;
    operand_b   = 32'd9;
    #1;
    chk("flush_t0_stall", 64'(stall), 64'(1));
    n_done = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (done) n_done++;
    end
    flush = 1'b1;
    #1;
    chk("flush_t10_stall", 64'(stall), 64'(1));
    step();
    flush     = 1'b0;
    alu_valid = 1'b0;
    #1;
    chk("flush_t11_busy", 64'(busy), 64'(0));
    chk("flush_t11_stall", 64'(stall), 64'(0));
    chk("flush_t11_hi", 64'(hi), 64'(last_hi));
    chk("flush_t11_lo", 64'(lo), 64'(last_lo));
    for (int k = 0; k < 40; k++) begin
      if (done) n_done++;
      step();
    end
    chk("flush_no_done", 64'(n_done), 64'(0));
    mult_op("m7x6", 32'd7, 32'd6);
    chk("m7x6_lo_const", 64'(lo), 64'(42));
    chk("m7x6_hi_const", 64'(hi), 64'(0));
    retire("m7x6");
    step();

    // Reset asserted at T5 of a run discards it and clears HI/LO.
    alu_valid   = 1'b1;
    alu_control = 4'd6;
    operand_a   = 32'hFFFF_FFF9;
    operand_b   = 32'd11;
    repeat (5) step();
    rst_n     = 1'b0;
    alu_valid = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_stall", 64'(stall), 64'(0));
    chk("midrst_hi", 64'(hi), 64'(0));
    chk("midrst_lo", 64'(lo), 64'(0));
    last_hi = '0;
    last_lo = '0;
    n_done  = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) n_done++;
      step();
    end
    chk("midrst_no_done", 64'(n_done), 64'(0));

    // MULT held valid through DONE: it is not restarted until IDLE.
    mult_op("held_a", 32'd12, 32'hFFFF_FFFD);
    step();
    mult_op("held_b", 32'hFFFF_FFF4, 32'd3);
    retire("held_b");
    step();

    // Random signed sweep, randomly mixing back-to-back issue and idle gaps.
    for (int i = 0; i < 1000; i++) begin
      mult_op("rnd", pick(), pick());
      step();
      if ($urandom_range(0, 1) == 0) begin
        alu_valid = 1'b0;
        #1;
        chk("rnd_done_once", 64'(done), 64'(0));
        chk("rnd_idle_busy", 64'(busy), 64'(0));
        repeat ($urandom_range(1, 3)) step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
